// File: rtl/pic_pkg.sv
// Shared constants for the 8259 command decoder: FSM state codes, OCW2 command codes
// and data-bus bit positions used when decoding ICW/OCW writes.
package pic_pkg;

   // Initialisation / operating states
   localparam logic [2:0] ST_UNINIT = 3'd0;
   localparam logic [2:0] ST_ICW2   = 3'd1;
   localparam logic [2:0] ST_ICW3   = 3'd2;
   localparam logic [2:0] ST_ICW4   = 3'd3;
   localparam logic [2:0] ST_READY  = 3'd4;

   // OCW2 {R,SL,EOI} command codes
   localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
   localparam logic [2:0] OCW2_NSEOI        = 3'b001;
   localparam logic [2:0] OCW2_NOP          = 3'b010;
   localparam logic [2:0] OCW2_SEOI         = 3'b011;
   localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
   localparam logic [2:0] OCW2_ROT_NSEOI    = 3'b101;
   localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
   localparam logic [2:0] OCW2_ROT_SEOI     = 3'b111;

   // Data-bus field positions
   localparam int D_ICW1_SEL = 4;
   localparam int D_OCW3_SEL = 3;
   localparam int D_LTIM     = 3;
   localparam int D_SNGL     = 1;
   localparam int D_IC4      = 0;
   localparam int D_AEOI     = 1;
   localparam int D_RR       = 1;
   localparam int D_RIS      = 0;
   localparam int D_POLL     = 2;

   typedef struct packed {
      logic       wev;
      logic       a0;
      logic [7:0] d;
   } wr_cap_t;

   function automatic logic is_icw1(input logic a0, input logic [7:0] d);
      return !a0 && d[D_ICW1_SEL];
   endfunction

endpackage

// File: rtl/pic_wr_strobe.sv
// CPU write capture: registers WR_n, holds CS_n/A0/data from the last low cycle and
// flags a single-cycle write event on the WR_n rising edge.
module pic_wr_strobe (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cs_n_i,
   input  logic       wr_n_i,
   input  logic       a0_i,
   input  logic [7:0] data_i,
   output logic       wev_o,
   output logic       a0_o,
   output logic [7:0] d_o
);
   import pic_pkg::*;

   logic       wr_q;
   logic       cs_n_q;
   logic       a0_q;
   logic [7:0] d_q;
   wr_cap_t    cap;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q   <= 1'b1;
         cs_n_q <= 1'b1;
         a0_q   <= 1'b0;
         d_q    <= 8'h00;
      end else begin
         wr_q <= wr_n_i;
         // Bus values are frozen once WR_n goes high so the event cycle sees the last low sample
         if (!wr_n_i) begin
            cs_n_q <= cs_n_i;
            a0_q   <= a0_i;
            d_q    <= data_i;
         end
      end
   end

   always_comb begin
      cap.wev = !wr_q && wr_n_i && !cs_n_q;
      cap.a0  = a0_q;
      cap.d   = d_q;
   end

   assign wev_o = cap.wev;
   assign a0_o  = cap.a0;
   assign d_o   = cap.d;

endmodule

// File: rtl/pic_control_logic.sv
// 8259 command decoder: ICW1..ICW4 initialisation then OCW1/2/3 decode.
// Optional PIC_POLL_CMD_EN adds a one-cycle poll_req pulse on OCW3 with D2=1.
module pic_control_logic #(
   parameter logic [7:0] IMR_INIT = 8'h00,
   parameter logic [2:0] NOP_CMD  = 3'b010
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       CS_n,
   input  logic       WR_n,
   input  logic       A0,
   input  logic [7:0] data_in,
   output logic [7:0] OCW1,
   output logic [4:0] VEC_ADD,
   output logic       LTIM,
   output logic       EOI_mode,
   output logic       read_mode,
   output logic [2:0] EOI_command,
   output logic [2:0] int_level,
   output logic       EOI_command_updated,
   output logic       sngl,
   output logic [7:0] icw3,
   output logic       init_done,
`ifdef PIC_POLL_CMD_EN
   output logic       poll_req,
`endif
   output logic [2:0] state_o
);
   import pic_pkg::*;

   logic       wev;
   logic       a0_cap;
   logic [7:0] d_cap;

   pic_wr_strobe u_wr_strobe (
      .clk_i  (clk),
      .rst_i  (rst),
      .cs_n_i (CS_n),
      .wr_n_i (WR_n),
      .a0_i   (A0),
      .data_i (data_in),
      .wev_o  (wev),
      .a0_o   (a0_cap),
      .d_o    (d_cap)
   );

   logic [2:0] state_q,     state_d;
   logic [7:0] ocw1_q,      ocw1_d;
   logic [4:0] vec_add_q,   vec_add_d;
   logic       ltim_q,      ltim_d;
   logic       eoi_mode_q,  eoi_mode_d;
   logic       read_mode_q, read_mode_d;
   logic [2:0] eoi_cmd_q,   eoi_cmd_d;
   logic [2:0] int_level_q, int_level_d;
   logic       eoi_upd_q,   eoi_upd_d;
   logic       sngl_q,      sngl_d;
   logic       ic4_q,       ic4_d;
   logic [7:0] icw3_q,      icw3_d;
   logic       poll_q,      poll_d;

   always_comb begin
      state_d     = state_q;
      ocw1_d      = ocw1_q;
      vec_add_d   = vec_add_q;
      ltim_d      = ltim_q;
      eoi_mode_d  = eoi_mode_q;
      read_mode_d = read_mode_q;
      eoi_cmd_d   = eoi_cmd_q;
      int_level_d = int_level_q;
      eoi_upd_d   = eoi_upd_q;
      sngl_d      = sngl_q;
      ic4_d       = ic4_q;
      icw3_d      = icw3_q;
      poll_d      = 1'b0;

      if (wev) begin
         // ICW1 restarts initialisation from any state
         if (is_icw1(a0_cap, d_cap)) begin
            ltim_d      = d_cap[D_LTIM];
            sngl_d      = d_cap[D_SNGL];
            ic4_d       = d_cap[D_IC4];
            ocw1_d      = IMR_INIT;
            read_mode_d = 1'b0;
            eoi_mode_d  = 1'b0;
            icw3_d      = 8'h00;
            state_d     = ST_ICW2;
         end else begin
            case (state_q)
               ST_ICW2: begin
                  if (a0_cap) begin
                     vec_add_d = d_cap[7:3];
                     if (!sngl_q)    state_d = ST_ICW3;
                     else if (ic4_q) state_d = ST_ICW4;
                     else            state_d = ST_READY;
                  end
               end
               ST_ICW3: begin
                  if (a0_cap) begin
                     icw3_d  = d_cap;
                     state_d = ic4_q ? ST_ICW4 : ST_READY;
                  end
               end
               ST_ICW4: begin
                  if (a0_cap) begin
                     eoi_mode_d = d_cap[D_AEOI];
                     state_d    = ST_READY;
                  end
               end
               ST_READY: begin
                  if (a0_cap) begin
                     ocw1_d = d_cap;
                  end else if (!d_cap[D_OCW3_SEL]) begin
                     eoi_cmd_d   = d_cap[7:5];
                     int_level_d = d_cap[2:0];
                     eoi_upd_d   = ~eoi_upd_q;
                  end else begin
                     if (d_cap[D_RR]) read_mode_d = d_cap[D_RIS];
`ifdef PIC_POLL_CMD_EN
                     poll_d = d_cap[D_POLL];
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_UNINIT;
         ocw1_q      <= IMR_INIT;
         vec_add_q   <= 5'd0;
         ltim_q      <= 1'b0;
         eoi_mode_q  <= 1'b0;
         read_mode_q <= 1'b0;
         eoi_cmd_q   <= NOP_CMD;
         int_level_q <= 3'd0;
         eoi_upd_q   <= 1'b0;
         sngl_q      <= 1'b0;
         ic4_q       <= 1'b0;
         icw3_q      <= 8'h00;
         poll_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ocw1_q      <= ocw1_d;
         vec_add_q   <= vec_add_d;
         ltim_q      <= ltim_d;
         eoi_mode_q  <= eoi_mode_d;
         read_mode_q <= read_mode_d;
         eoi_cmd_q   <= eoi_cmd_d;
         int_level_q <= int_level_d;
         eoi_upd_q   <= eoi_upd_d;
         sngl_q      <= sngl_d;
         ic4_q       <= ic4_d;
         icw3_q      <= icw3_d;
         poll_q      <= poll_d;
      end
   end

   assign OCW1                = ocw1_q;
   assign VEC_ADD             = vec_add_q;
   assign LTIM                = ltim_q;
   assign EOI_mode            = eoi_mode_q;
   assign read_mode           = read_mode_q;
   assign EOI_command         = eoi_cmd_q;
   assign int_level           = int_level_q;
   assign EOI_command_updated = eoi_upd_q;
   assign sngl                = sngl_q;
   assign icw3                = icw3_q;
   assign init_done           = (state_q == ST_READY);
   assign state_o             = state_q;
`ifdef PIC_POLL_CMD_EN
   assign poll_req            = poll_q;
`else
   logic unused_poll;
   assign unused_poll = poll_q;
`endif

endmodule

// File: tb/tb_pic_control_logic.sv
// Directed bench for pic_control_logic: init sequences, OCW decode, restart and reset corner cases.
module tb_pic_control_logic;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       CS_n = 1'b1;
   logic       WR_n = 1'b1;
   logic       A0 = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] OCW1;
   logic [4:0] VEC_ADD;
   logic       LTIM, EOI_mode, read_mode, EOI_command_updated, sngl, init_done;
   logic [2:0] EOI_command, int_level, state_o;
   logic [7:0] icw3;
`ifdef PIC_POLL_CMD_EN
   logic       poll_req;
`endif

   int n_vec = 0;
   int n_err = 0;

   localparam logic [2:0] S_UNINIT = 3'd0;
   localparam logic [2:0] S_ICW2   = 3'd1;
   localparam logic [2:0] S_ICW3   = 3'd2;
   localparam logic [2:0] S_ICW4   = 3'd3;
   localparam logic [2:0] S_READY  = 3'd4;

   pic_control_logic dut (
      .clk                 (clk),
      .rst                 (rst),
      .CS_n                (CS_n),
      .WR_n                (WR_n),
      .A0                  (A0),
      .data_in             (data_in),
      .OCW1                (OCW1),
      .VEC_ADD             (VEC_ADD),
      .LTIM                (LTIM),
      .EOI_mode            (EOI_mode),
      .read_mode           (read_mode),
      .EOI_command         (EOI_command),
      .int_level           (int_level),
      .EOI_command_updated (EOI_command_updated),
      .sngl                (sngl),
      .icw3                (icw3),
      .init_done           (init_done),
`ifdef PIC_POLL_CMD_EN
      .poll_req            (poll_req),
`endif
      .state_o             (state_o)
   );

   always #5 clk = ~clk;

   // Called at a negedge; one low cycle, one high cycle, returns at the negedge after the update.
   task automatic wr(input logic a0, input logic [7:0] d, input logic cs_n);
      CS_n = cs_n; A0 = a0; data_in = d; WR_n = 1'b0;
      @(negedge clk);
      WR_n = 1'b1; CS_n = 1'b1; A0 = 1'b0; data_in = 8'h00;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (OCW1 !== 8'h00) begin n_err++; $display("FAIL reset_ocw1 got %h exp 00", OCW1); end
      n_vec++; if (EOI_command !== 3'b010) begin n_err++; $display("FAIL reset_eoi_cmd got %b exp 010", EOI_command); end
      n_vec++; if ({VEC_ADD, LTIM, EOI_mode, read_mode, int_level, EOI_command_updated, sngl, icw3, init_done} !== 22'h0)
         begin n_err++; $display("FAIL reset_misc got %h exp 0", {VEC_ADD, LTIM, EOI_mode, read_mode, int_level, EOI_command_updated, sngl, icw3, init_done}); end
      n_vec++; if (state_o !== S_UNINIT) begin n_err++; $display("FAIL reset_state got %0d exp %0d", state_o, S_UNINIT); end
   endtask

   task automatic test_uninit_ignore();
      wr(1'b1, 8'h55, 1'b0);
      wr(1'b0, 8'h0B, 1'b0);
      n_vec++; if (OCW1 !== 8'h00) begin n_err++; $display("FAIL uninit_ocw1 got %h exp 00", OCW1); end
      n_vec++; if (read_mode !== 1'b0) begin n_err++; $display("FAIL uninit_read_mode got %b exp 0", read_mode); end
      n_vec++; if (state_o !== S_UNINIT) begin n_err++; $display("FAIL uninit_state got %0d exp %0d", state_o, S_UNINIT); end
   endtask

   task automatic test_init_icw4();
      wr(1'b0, 8'h13, 1'b0);
      n_vec++; if (state_o !== S_ICW2 || sngl !== 1'b1 || LTIM !== 1'b0)
         begin n_err++; $display("FAIL icw1_13 got state=%0d sngl=%b ltim=%b exp 1/1/0", state_o, sngl, LTIM); end
      wr(1'b1, 8'h48, 1'b0);
      n_vec++; if (VEC_ADD !== 5'h09) begin n_err++; $display("FAIL icw2_vec got %h exp 09", VEC_ADD); end
      n_vec++; if (state_o !== S_ICW4 || init_done !== 1'b0)
         begin n_err++; $display("FAIL icw2_skip_icw3 got state=%0d done=%b exp %0d/0", state_o, init_done, S_ICW4); end
      wr(1'b1, 8'h02, 1'b0);
      n_vec++; if (EOI_mode !== 1'b1) begin n_err++; $display("FAIL icw4_aeoi got %b exp 1", EOI_mode); end
      n_vec++; if (state_o !== S_READY || init_done !== 1'b1 || icw3 !== 8'h00)
         begin n_err++; $display("FAIL icw4_ready got state=%0d done=%b icw3=%h exp %0d/1/00", state_o, init_done, icw3, S_READY); end
   endtask

   task automatic test_init_icw3();
      wr(1'b0, 8'h10, 1'b0);
      n_vec++; if (EOI_mode !== 1'b0 || init_done !== 1'b0 || state_o !== S_ICW2)
         begin n_err++; $display("FAIL icw1_10 got aeoi=%b done=%b state=%0d exp 0/0/%0d", EOI_mode, init_done, state_o, S_ICW2); end
      wr(1'b0, 8'h20, 1'b0);
      n_vec++; if (state_o !== S_ICW2 || EOI_command !== 3'b010)
         begin n_err++; $display("FAIL icw2_a0low_ignored got state=%0d cmd=%b exp %0d/010", state_o, EOI_command, S_ICW2); end
      wr(1'b1, 8'h20, 1'b0);
      n_vec++; if (VEC_ADD !== 5'h04 || state_o !== S_ICW3)
         begin n_err++; $display("FAIL icw2_to_icw3 got vec=%h state=%0d exp 04/%0d", VEC_ADD, state_o, S_ICW3); end
      wr(1'b1, 8'h04, 1'b0);
      n_vec++; if (icw3 !== 8'h04) begin n_err++; $display("FAIL icw3_val got %h exp 04", icw3); end
      n_vec++; if (state_o !== S_READY || init_done !== 1'b1 || EOI_mode !== 1'b0)
         begin n_err++; $display("FAIL icw3_ready got state=%0d done=%b aeoi=%b exp %0d/1/0", state_o, init_done, EOI_mode, S_READY); end
   endtask

   task automatic test_ocw();
      logic upd0;
      wr(1'b1, 8'hA5, 1'b0);
      n_vec++; if (OCW1 !== 8'hA5) begin n_err++; $display("FAIL ocw1 got %h exp a5", OCW1); end
      upd0 = EOI_command_updated;
      wr(1'b0, 8'h20, 1'b0);
      n_vec++; if (EOI_command !== 3'b001 || int_level !== 3'd0 || EOI_command_updated !== ~upd0)
         begin n_err++; $display("FAIL ocw2_first got cmd=%b lvl=%0d upd=%b exp 001/0/%b", EOI_command, int_level, EOI_command_updated, ~upd0); end
      wr(1'b0, 8'h20, 1'b0);
      n_vec++; if (EOI_command !== 3'b001 || EOI_command_updated !== upd0)
         begin n_err++; $display("FAIL ocw2_repeat got cmd=%b upd=%b exp 001/%b", EOI_command, EOI_command_updated, upd0); end
      wr(1'b0, 8'h63, 1'b0);
      n_vec++; if (EOI_command !== 3'b011 || int_level !== 3'd3 || EOI_command_updated !== ~upd0)
         begin n_err++; $display("FAIL ocw2_seoi got cmd=%b lvl=%0d upd=%b exp 011/3/%b", EOI_command, int_level, EOI_command_updated, ~upd0); end
      n_vec++; if (OCW1 !== 8'hA5) begin n_err++; $display("FAIL ocw1_kept got %h exp a5", OCW1); end
   endtask

   task automatic test_ocw3();
      wr(1'b0, 8'h0B, 1'b0);
      n_vec++; if (read_mode !== 1'b1) begin n_err++; $display("FAIL ocw3_ris got %b exp 1", read_mode); end
      wr(1'b0, 8'h08, 1'b0);
      n_vec++; if (read_mode !== 1'b1) begin n_err++; $display("FAIL ocw3_hold got %b exp 1", read_mode); end
      wr(1'b0, 8'h0A, 1'b0);
      n_vec++; if (read_mode !== 1'b0) begin n_err++; $display("FAIL ocw3_irr got %b exp 0", read_mode); end
   endtask

   task automatic test_cs_high();
      wr(1'b1, 8'h3C, 1'b1);
      n_vec++; if (OCW1 !== 8'hA5) begin n_err++; $display("FAIL cs_high_ocw1 got %h exp a5", OCW1); end
   endtask

   task automatic test_restart();
      logic upd0;
      wr(1'b0, 8'h13, 1'b0);
      wr(1'b1, 8'h48, 1'b0);
      upd0 = EOI_command_updated;
      wr(1'b0, 8'h1B, 1'b0);
      n_vec++; if (LTIM !== 1'b1 || init_done !== 1'b0 || state_o !== S_ICW2)
         begin n_err++; $display("FAIL restart got ltim=%b done=%b state=%0d exp 1/0/%0d", LTIM, init_done, state_o, S_ICW2); end
      n_vec++; if (OCW1 !== 8'h00) begin n_err++; $display("FAIL restart_imr got %h exp 00", OCW1); end
      wr(1'b0, 8'h20, 1'b0);
      wr(1'b0, 8'h0B, 1'b0);
      n_vec++; if (EOI_command !== 3'b011 || EOI_command_updated !== upd0 || read_mode !== 1'b0)
         begin n_err++; $display("FAIL restart_ocw_ignored got cmd=%b upd=%b rm=%b exp 011/%b/0", EOI_command, EOI_command_updated, read_mode, upd0); end
      n_vec++; if (state_o !== S_ICW2 || init_done !== 1'b0)
         begin n_err++; $display("FAIL restart_state got state=%0d done=%b exp %0d/0", state_o, init_done, S_ICW2); end
   endtask

   task automatic test_reset_mid_write();
      CS_n = 1'b0; A0 = 1'b0; data_in = 8'h1B; WR_n = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; WR_n = 1'b1; CS_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (state_o !== S_UNINIT || LTIM !== 1'b0 || sngl !== 1'b0)
         begin n_err++; $display("FAIL rst_mid_write got state=%0d ltim=%b sngl=%b exp 0/0/0", state_o, LTIM, sngl); end
      n_vec++; if (EOI_command !== 3'b010 || VEC_ADD !== 5'h00 || init_done !== 1'b0)
         begin n_err++; $display("FAIL rst_values got cmd=%b vec=%h done=%b exp 010/00/0", EOI_command, VEC_ADD, init_done); end
   endtask

`ifdef PIC_POLL_CMD_EN
   task automatic test_poll();
      wr(1'b0, 8'h12, 1'b0);
      wr(1'b1, 8'h00, 1'b0);
      wr(1'b0, 8'h0B, 1'b0);
      n_vec++; if (poll_req !== 1'b0 || state_o !== S_READY)
         begin n_err++; $display("FAIL poll_idle got poll=%b state=%0d exp 0/%0d", poll_req, state_o, S_READY); end
      wr(1'b0, 8'h0C, 1'b0);
      n_vec++; if (poll_req !== 1'b1 || read_mode !== 1'b1)
         begin n_err++; $display("FAIL poll_pulse got poll=%b rm=%b exp 1/1", poll_req, read_mode); end
      @(negedge clk);
      n_vec++; if (poll_req !== 1'b0) begin n_err++; $display("FAIL poll_one_cycle got %b exp 0", poll_req); end
   endtask
`endif

   initial begin
      test_reset();
      test_uninit_ignore();
      test_init_icw4();
      test_init_icw3();
      test_ocw();
      test_ocw3();
      test_cs_high();
      test_restart();
      test_reset_mid_write();
`ifdef PIC_POLL_CMD_EN
      test_poll();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
